gcd_processor_n: RTL
====================

// Module: gcd_processor_n
// PURPOSE
//  Parametrised successor to the fixed 8-bit GCD processor. Operator enters X then Y
//  on dataIn, each with an active-low enter pulse. Block computes GCD(X,Y) by repeated
//  subtraction, shows the working value on dataOut and raises halt when done.
//  New features: width parameter, zero-operand handling with an error flag, a step
//  counter and an explicit busy output. Sits between operator I/O and the display.
// PARAMETERS
//  WIDTH   8   operand / result width in bits
//  CNT_W   16  step-counter width (saturates, no wrap)
// PORTS
//  clock    in   1      system clock, rising edge
//  reset    in   1      asynchronous, active-low; clears all state
//  enter    in   1      active-low strobe; a 1->0 transition = one entry event
//  dataIn   in   WIDTH  operand, sampled on the cycle the entry event is detected
//  dataOut  out  WIDTH  working X while computing; GCD result while halt=1
//  halt     out  1      1 = result valid; held until the next entry event
//  busy     out  1      1 while in COMPUTE
//  zero_err out  1      1 with halt when X=0 and Y=0 (result 0)
//  steps    out  CNT_W  subtraction steps used by the last/current computation
// BEHAVIOUR
//  Reset (reset=0, async): state=WAIT_X; dataOut, halt, busy, zero_err, steps = 0;
//   edge-detect register = 1, so an enter held low through reset release is no event.
//  Entry event: enter_q<=enter every clock; event = enter_q & ~enter. An enter held
//   low for many cycles counts once.
//  FSM states:
//   WAIT_X : on event, X<=dataIn, dataOut<=dataIn, clear halt/zero_err/steps -> WAIT_Y
//   WAIT_Y : on event, Y<=dataIn -> COMPUTE (busy=1 from the next edge)
//   COMPUTE: one action per clock, evaluated in this order:
//            X==0 & Y==0 -> result 0, zero_err<=1 -> DONE
//            X==0 -> result Y ; Y==0 -> result X ; X==Y -> result X -> DONE
//            X>Y -> X<=X-Y, steps++ ; else Y<=Y-X, steps++
//            dataOut<=X every COMPUTE cycle
//   DONE   : halt=1, busy=0, dataOut=result; on event -> same action as WAIT_X
//            (the event data is taken as the new X; back-to-back runs need no idle gap)
//  Entry events during COMPUTE are ignored (no queueing).
//  Subtraction is unsigned WIDTH bits; operands only shrink, so no overflow.
//  steps saturates at 2^CNT_W-1. Worst case (X=2^WIDTH-1, Y=1) needs 2^WIDTH-2 steps.
//  Latency: halt rises on the edge that follows the terminating COMPUTE cycle.
//   Total cycles from the Y event to halt = steps+2.
//  Reset mid-operation: aborts immediately to the reset values; no partial result kept.
//  dataIn changes outside an event cycle have no effect.
// STRUCTURE
//  gcd_defs.vh: state encodings (WAIT_X, WAIT_Y, COMPUTE, DONE) and default widths,
//   shared with the display and testbench.
//  Sub-module enter_edge_det: registered active-low falling-edge detector with async
//   reset preset to 1; used by this block and future operator-input blocks.
//  Datapath (X, Y, comparator, subtractor, step counter) and the FSM stay in this module.
// TESTING
//  W=8: X=50,Y=20 -> X goes 30,10; halt=1, dataOut=10, steps=2, zero_err=0
//  W=8: X=17,Y=5 -> dataOut=1, halt=1; X=0,Y=9 -> dataOut=9, steps=0
//  W=8: X=0,Y=0 -> halt=1, dataOut=0, zero_err=1; next run X=12,Y=8 -> zero_err=0, 4
//  enter held low 10 cycles during WAIT_X -> exactly one capture; pulse in COMPUTE ignored
//  reset=0 during COMPUTE of X=200,Y=3 -> all outputs 0 at once; resume -> clean new run
//  W=16: X=48000,Y=36000 -> dataOut=12000, steps=3; back-to-back from DONE with X=9,Y=6 -> 3

Source files
------------

// File: rtl/gcd_processor_n_pkg.sv
// Shared definitions for the parametrised GCD processor: default widths,
// FSM state encodings and the status flag bundle.
package gcd_processor_n_pkg;

  localparam int unsigned GCD_WIDTH_DEF = 8;
  localparam int unsigned GCD_CNT_W_DEF = 16;
  localparam int unsigned GCD_ST_W      = 2;

  localparam logic [GCD_ST_W-1:0] ST_WAIT_X  = 2'd0;
  localparam logic [GCD_ST_W-1:0] ST_WAIT_Y  = 2'd1;
  localparam logic [GCD_ST_W-1:0] ST_COMPUTE = 2'd2;
  localparam logic [GCD_ST_W-1:0] ST_DONE    = 2'd3;

  typedef struct packed {
    logic halt;
    logic busy;
    logic zero_err;
  } gcd_flags_t;

endpackage

// File: rtl/gcd_processor_n_if.sv
// Operator-entry and display-side signals of the GCD processor.
interface gcd_processor_n_if
  import gcd_processor_n_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF,
  parameter int unsigned CNT_W = GCD_CNT_W_DEF
);

  logic             enter_n_i;
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic             halt_o;
  logic             busy_o;
  logic             zero_err_o;
  logic [CNT_W-1:0] steps_o;

  modport master (
    output enter_n_i, data_i,
    input  data_o, halt_o, busy_o, zero_err_o, steps_o
  );

  modport slave (
    input  enter_n_i, data_i,
    output data_o, halt_o, busy_o, zero_err_o, steps_o
  );

endinterface

// File: rtl/gcd_processor_n_enter_edge_det.sv
// Registered falling-edge detector for an active-low operator strobe; the
// history register resets to the idle level so a long-held press counts once.
module enter_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic enter_n_i,
  output logic fall_c
);

  logic enter_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) enter_q <= 1'b1;
    else        enter_q <= enter_n_i;
  end

  assign fall_c = enter_q & ~enter_n_i;

endmodule

// File: rtl/gcd_processor_n.sv
// GCD by repeated subtraction with operator entry of X then Y, a saturating
// step counter, busy/halt status and a zero-operand error flag.
module gcd_processor_n
  import gcd_processor_n_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH_DEF,
  parameter int unsigned CNT_W = GCD_CNT_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  gcd_processor_n_if.slave bus_s
);

  logic                fall_c;
  logic [GCD_ST_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [WIDTH-1:0]    y_q, y_d;
  logic [WIDTH-1:0]    data_q, data_d;
  gcd_flags_t          flags_q, flags_d;
  logic [CNT_W-1:0]    steps_q, steps_d;
  logic                x_zero_c, y_zero_c, term_c, steps_max_c;

  enter_edge_det u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .enter_n_i (bus_s.enter_n_i),
    .fall_c    (fall_c)
  );

  assign x_zero_c    = (x_q == '0);
  assign y_zero_c    = (y_q == '0);
  assign term_c      = x_zero_c | y_zero_c | (x_q == y_q);
  assign steps_max_c = &steps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_X;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    flags_d = flags_q;
    steps_d = steps_q;

    case (state_q)
      // A finished run accepts the next X directly, like the idle state.
      ST_WAIT_X, ST_DONE: begin
        if (fall_c) begin
          x_d     = bus_s.data_i;
          data_d  = bus_s.data_i;
          flags_d = '0;
          steps_d = '0;
          state_d = ST_WAIT_Y;
        end
      end

      ST_WAIT_Y: begin
        if (fall_c) begin
          y_d          = bus_s.data_i;
          flags_d.busy = 1'b1;
          state_d      = ST_COMPUTE;
        end
      end

      ST_COMPUTE: begin
        data_d = x_q;
        if (term_c) begin
          // X==0 yields Y (which also covers 0,0 -> 0); otherwise X is the GCD.
          data_d           = x_zero_c ? y_q : x_q;
          flags_d.halt     = 1'b1;
          flags_d.busy     = 1'b0;
          flags_d.zero_err = x_zero_c & y_zero_c;
          state_d          = ST_DONE;
        end else begin
          if (x_q > y_q) x_d = x_q - y_q;
          else           y_d = y_q - x_q;
          steps_d = steps_max_c ? steps_q : steps_q + CNT_W'(1);
        end
      end

      default: state_d = ST_WAIT_X;
    endcase
  end

  assign bus_s.data_o     = data_q;
  assign bus_s.halt_o     = flags_q.halt;
  assign bus_s.busy_o     = flags_q.busy;
  assign bus_s.zero_err_o = flags_q.zero_err;
  assign bus_s.steps_o    = steps_q;

endmodule
